dmem_responder: RTL and testbench



---
 rtl/dmem_if.sv | 36 +++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Data-memory request/grant/response bundle between the core (master) and a
// memory responder (slave).
//   req    : request valid from the core
//   we     : 1 = store, 0 = load
//   addr   : byte address
//   be     : store byte enables, bit n covers wdata[8n+7:8n]
//   wdata  : store data
//   gnt    : responder can accept a request this cycle
//   rvalid : one-cycle response strobe
//   rdata  : load data (0 for stores and errors)
//   err    : response is an error, qualified by rvalid
interface dmem_if #(
    parameter int unsigned XLEN = 32
) ();

    logic                req;
    logic                we;
    logic [XLEN-1:0]     addr;
    logic [XLEN/8-1:0]   be;
    logic [XLEN-1:0]     wdata;
    logic                gnt;
    logic                rvalid;
    logic [XLEN-1:0]     rdata;
    logic                err;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the core's load/store handshake. Holds a
// word-organised, byte-writable RAM and answers each accepted request with one
// response strobe LATENCY cycles after the accept edge.
//   clk_i      : clock, all state on rising edge
//   rst_i      : asynchronous active-high reset (RAM is not cleared)
//   bus        : dmem_if slave modport (req/we/addr/be/wdata in, gnt/rvalid/rdata/err out)
//   dbg_addr_i : word index for the debug peek
//   dbg_data_o : combinational RAM[dbg_addr_i]
module dmem_responder #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     MEM_WORDS = 2048,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned     LATENCY   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    dmem_if.slave                        bus,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr_i,
    output logic [XLEN-1:0]              dbg_data_o
);

    localparam int unsigned     AW        = $clog2(MEM_WORDS);
    localparam int unsigned     NBYTES    = XLEN / 8;
    localparam int unsigned     CNT_W     = 3;
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS * 4);
    // Wait-count preload; unused when LATENCY is 1 (accept goes straight to RESP)
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               gnt_q;
    logic               rvalid_q;
    logic [XLEN-1:0]    rdata_q;
    logic               err_q;
    logic [XLEN-1:0]    pend_data_q;
    logic               pend_err_q;

    logic [XLEN-1:0]    mem [MEM_WORDS];

    logic               accept_c;
    logic [XLEN-1:0]    off_c;
    logic               dec_err_c;
    logic [AW-1:0]      idx_c;
    logic [XLEN-1:0]    load_data_c;
    logic               wr_en_c;
    logic [XLEN-1:0]    resp_data_c;
    logic               resp_err_c;

    // Address decode; the subtraction wraps so addresses below BASE_ADDR land out of range
    always_comb begin
        off_c       = bus.addr - BASE_ADDR;
        dec_err_c   = (off_c[1:0] != 2'b00) || (off_c >= MEM_BYTES);
        idx_c       = off_c[AW+1:2];
        load_data_c = (!bus.we && !dec_err_c) ? mem[idx_c] : '0;
        wr_en_c     = accept_c && bus.we && !dec_err_c;
    end

    // With LATENCY 1 the response is loaded on the accept edge itself, so bypass the pending regs
    always_comb begin
        resp_data_c = accept_c ? load_data_c : pend_data_q;
        resp_err_c  = accept_c ? dec_err_c   : pend_err_q;
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state; accept is masked during reset so no RAM write can slip through
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req && !rst_i) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered handshake outputs and response payload, held until the next response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q       <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            pend_data_q <= '0;
            pend_err_q  <= 1'b0;
        end else begin
            gnt_q    <= (state_d == S_IDLE);
            rvalid_q <= (state_d == S_RESP);
            if (state_d == S_RESP) begin
                rdata_q <= resp_data_c;
                err_q   <= resp_err_c;
            end
            if (accept_c) begin
                pend_data_q <= load_data_c;
                pend_err_q  <= dec_err_c;
            end
        end
    end

    // Byte-lane RAM write at the accept edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (bus.be[b]) begin
                    mem[idx_c][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign dbg_data_o = mem[dbg_addr_i];

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY 1 and one at LATENCY 4,
// each with a reference RAM model and a response scoreboard that also checks
// the exact response cycle.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1, rst4;
    logic [10:0] dbg1, dbg4;
    logic [31:0] dbgd1, dbgd4;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fails = 0;

    exp_t        q1[$];
    exp_t        q4[$];
    logic [31:0] m1 [2048];
    logic [31:0] m4 [2048];

    dmem_if #(.XLEN(32)) bus1 ();
    dmem_if #(.XLEN(32)) bus4 ();

    dmem_responder #(.LATENCY(1)) u_dut1 (
        .clk_i      (clk),
        .rst_i      (rst1),
        .bus        (bus1),
        .dbg_addr_i (dbg1),
        .dbg_data_o (dbgd1)
    );

    dmem_responder #(.LATENCY(4)) u_dut4 (
        .clk_i      (clk),
        .rst_i      (rst4),
        .bus        (bus4),
        .dbg_addr_i (dbg4),
        .dbg_data_o (dbgd4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboards: every strobe must match the oldest expectation, including its cycle
    always @(negedge clk) begin
        if (bus1.rvalid) begin
            if (q1.size() == 0) begin
                chk_eq("rv1_spurious", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk_eq("rv1_cycle", 32'(cyc), 32'(e.cyc));
                chk_eq("rv1_rdata", bus1.rdata, e.rdata);
                chk_eq("rv1_err", 32'(bus1.err), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (bus4.rvalid) begin
            if (q4.size() == 0) begin
                chk_eq("rv4_spurious", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk_eq("rv4_cycle", 32'(cyc), 32'(e.cyc));
                chk_eq("rv4_rdata", bus4.rdata, e.rdata);
                chk_eq("rv4_err", 32'(bus4.err), 32'(e.err));
            end
        end
    end

    // Drive a request, wait for grant, push the expected response, return at the
    // negedge after the accept edge with req still asserted.
    task automatic issue(input bit sel, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] off;
        logic [10:0] idx;
        logic        err;
        logic [31:0] w;
        int          n;
        if (sel) begin
            bus4.req = 1'b1; bus4.we = we; bus4.addr = addr; bus4.be = be; bus4.wdata = wdata;
        end else begin
            bus1.req = 1'b1; bus1.we = we; bus1.addr = addr; bus1.be = be; bus1.wdata = wdata;
        end
        n = 0;
        while (!(sel ? bus4.gnt : bus1.gnt) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk_eq("gnt_timeout", 32'd0, 32'd1);
        off = addr - BASE;
        err = (off[1:0] != 2'b00) || (off >= 32'd8192);
        idx = off[12:2];
        e.cyc = cyc + (sel ? 4 : 1);
        e.rdata = 32'h0;
        e.err = err;
        if (!err) begin
            w = sel ? m4[idx] : m1[idx];
            if (we) begin
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                if (sel) m4[idx] = w; else m1[idx] = w;
            end else begin
                e.rdata = w;
            end
        end
        if (sel) q4.push_back(e); else q1.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk_eq("drain_timeout", 32'(q1.size() + q4.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int          k;
        logic [31:0] v;
        rst1 = 1'b1; rst4 = 1'b1;
        dbg1 = '0; dbg4 = '0;
        bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.be = '0; bus1.wdata = '0;
        bus4.req = 1'b0; bus4.we = 1'b0; bus4.addr = '0; bus4.be = '0; bus4.wdata = '0;
        for (int i = 0; i < 2048; i++) begin
            m1[i] = '0;
            m4[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_eq("rst_rvalid1", 32'(bus1.rvalid), 32'd0);
        chk_eq("rst_rdata1", bus1.rdata, 32'h0);
        chk_eq("rst_err1", 32'(bus1.err), 32'd0);
        chk_eq("rst_rvalid4", 32'(bus4.rvalid), 32'd0);
        rst1 = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        chk_eq("gnt1_after_rst", 32'(bus1.gnt), 32'd1);
        chk_eq("gnt4_after_rst", 32'(bus4.gnt), 32'd1);

        // Full-word store, then peek
        issue(0, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
        bus1.req = 1'b0;
        @(negedge clk);
        dbg1 = 11'd4; #1;
        chk_eq("dbg_full_store", dbgd1, 32'hDEAD_BEEF);

        // Partial store of lane 1, then peek and load back
        issue(0, 1'b1, 32'h8000_0010, 4'b0010, 32'h0000_5500);
        bus1.req = 1'b0;
        @(negedge clk);
        #1;
        chk_eq("dbg_partial_store", dbgd1, 32'hDEAD_55EF);
        issue(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
        bus1.req = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rdata_held", bus1.rdata, 32'hDEAD_55EF);

        // be = 0 store is a normal no-op
        issue(0, 1'b1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF);
        bus1.req = 1'b0;
        @(negedge clk);
        #1;
        chk_eq("dbg_be0_noop", dbgd1, 32'hDEAD_55EF);

        // Error cases; word 0 is seeded so an aliased out-of-range write would show
        issue(0, 1'b1, 32'h8000_0000, 4'hF, 32'h0BAD_F00D);
        issue(0, 1'b0, 32'h8000_0002, 4'h0, 32'h0);
        issue(0, 1'b1, 32'h8000_2000, 4'hF, 32'hFFFF_FFFF);
        issue(0, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0);
        issue(0, 1'b1, 32'h8000_0011, 4'hF, 32'h1111_1111);
        issue(0, 1'b0, 32'h8000_1FFC, 4'h0, 32'h0);
        bus1.req = 1'b0;
        @(negedge clk);
        dbg1 = 11'd0; #1;
        chk_eq("dbg_oor_store_blocked", dbgd1, 32'h0BAD_F00D);
        dbg1 = 11'd4; #1;
        chk_eq("dbg_misaligned_store_blocked", dbgd1, 32'hDEAD_55EF);

        // Back-to-back alternating store/load with req held high throughout
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            issue(0, 1'b1, BASE + 32'(i * 4), 4'hF, v);
            issue(0, 1'b0, BASE + 32'(i * 4), 4'h0, 32'h0);
        end
        bus1.req = 1'b0;
        drain();

        // LATENCY 4: store, then a load held high through WAIT/RESP
        issue(1, 1'b1, 32'h8000_0008, 4'hF, 32'hA5A5_0F0F);
        bus4.we = 1'b0; bus4.be = 4'h0; bus4.wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk_eq("l4_gnt_low", 32'(bus4.gnt), 32'd0);
            @(negedge clk);
        end
        chk_eq("l4_gnt_back", 32'(bus4.gnt), 32'd1);
        issue(1, 1'b0, 32'h8000_0008, 4'h0, 32'h0);
        bus4.req = 1'b0;
        drain();

        // Reset in the middle of a LATENCY 4 store: response dropped, write kept
        issue(1, 1'b1, 32'h8000_0020, 4'hF, 32'h1234_5678);
        bus4.req = 1'b0;
        k = cyc;
        @(negedge clk);
        rst4 = 1'b1;
        q4.delete();
        #1;
        chk_eq("midrst_rvalid", 32'(bus4.rvalid), 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        repeat (8) @(negedge clk);
        chk_eq("midrst_gnt", 32'(bus4.gnt), 32'd1);
        chk_eq("midrst_rdata", bus4.rdata, 32'h0);
        chk_eq("midrst_err", 32'(bus4.err), 32'd0);
        chk_eq("midrst_elapsed", 32'(cyc - k), 32'd10);
        dbg4 = 11'd8; #1;
        chk_eq("midrst_dbg_word8", dbgd4, 32'h1234_5678);

        // RAM survives reset: load the committed word back
        @(negedge clk);
        issue(1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
        bus4.req = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
